// File: rtl/ahb_arbiter_n_pkg.sv
// Shared encodings for the N-master AHB-style bus arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    REL  = 2'b11
  } state_e;

  // Owner-id width; a lone bit still suffices for two masters.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_arbiter_n_if.sv
// Request/response and grant bundle between the masters, slave and arbiter.
interface ahb_arbiter_n_if import ahb_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2
);
  localparam int ID_W = id_w(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] busreq;
  logic                   ready;
  resp_e                  response;
  logic [NUM_MASTERS-1:0] hsplit;
  logic [NUM_MASTERS-1:0] grant;
  logic [ID_W-1:0]        master_id;
  logic                   addr_phase;
  logic                   data_phase;
  logic [NUM_MASTERS-1:0] split_mask;
  logic                   error;

  modport master (
    input  busreq, ready, response, hsplit,
    output grant, master_id, addr_phase, data_phase, split_mask, error
  );

  modport slave (
    output busreq, ready, response, hsplit,
    input  grant, master_id, addr_phase, data_phase, split_mask, error
  );
endinterface

// File: rtl/ahb_arbiter_n_picker.sv
// Combinational winner selection: lowest index first, or rotating from ptr+1.
// Zero latency; no handshake.
module rr_priority_picker import ahb_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  localparam int ID_W = id_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [ID_W-1:0]        ptr_i,
  input  logic                   rr_en_i,
  output logic [NUM_MASTERS-1:0] onehot_o,
  output logic [ID_W-1:0]        idx_o
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = rr_en_i ? ID_W'((int'(ptr_i) + 1 + k) % NUM_MASTERS) : ID_W'(k);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_n.sv
// N-master bus arbiter: registered one-hot grant, 1 clock from IDLE/REL to ADDR.
// Slave stalls via ready; SPLIT parks the owner until its hsplit strobe.
module ahb_arbiter_n import ahb_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int RR_MODE     = 0,
  parameter int MAX_HOLD    = 16,
  localparam int ID_W = id_w(NUM_MASTERS)
) (
  input  logic            clk,
  input  logic            rst,
  ahb_arbiter_n_if.master bus
);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [7:0]             hold_q, hold_d;
  logic [NUM_MASTERS-1:0] split_q, split_d;
  logic                   error_q, error_d;
  logic                   rearb;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [ID_W-1:0]        pick_idx;

  assign eligible = bus.busreq & ~split_q;

  rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req_i    (eligible),
    .ptr_i    (rr_q),
    .rr_en_i  (RR_MODE != 0),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    split_d = split_q & ~bus.hsplit;
    error_d = 1'b0;
    rearb   = 1'b0;
    case (state_q)
      IDLE, REL: rearb = 1'b1;
      ADDR: if (bus.ready) state_d = DATA;
      DATA: begin
        if (bus.ready) begin
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
          if (bus.busreq[id_q] && (int'(hold_q) + 1 < MAX_HOLD)) state_d = ADDR;
          else rearb = 1'b1;
        end else if (bus.response != RESP_OKAY) begin
          // First cycle of a two-cycle response; REL absorbs the second.
          state_d = REL;
          grant_d = '0;
          if (bus.response == RESP_SPLIT) split_d[id_q] = 1'b1;
          if (bus.response == RESP_ERROR) error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rearb) begin
      if (|eligible) begin
        state_d = ADDR;
        grant_d = pick_oh;
        id_d    = pick_idx;
        rr_d    = pick_idx;
        hold_d  = '0;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      split_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      split_q <= split_d;
      error_q <= error_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.master_id  = id_q;
  assign bus.addr_phase = (state_q == ADDR);
  assign bus.data_phase = (state_q == DATA);
  assign bus.split_mask = split_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_ahb_arbiter_n.sv
// Directed bench: fixed-priority, round-robin, hold limit, SPLIT/ERROR/RETRY and async reset.
module tb_ahb_arbiter_n;
  import ahb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ahb_arbiter_n_if #(.NUM_MASTERS(2)) fb ();
  ahb_arbiter_n_if #(.NUM_MASTERS(4)) rb ();
  ahb_arbiter_n_if #(.NUM_MASTERS(2)) hb ();

  ahb_arbiter_n #(.NUM_MASTERS(2), .RR_MODE(0), .MAX_HOLD(16)) u_fix (.clk(clk), .rst(rst), .bus(fb));
  ahb_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(1))  u_rr  (.clk(clk), .rst(rst), .bus(rb));
  ahb_arbiter_n #(.NUM_MASTERS(2), .RR_MODE(1), .MAX_HOLD(4))  u_h   (.clk(clk), .rst(rst), .bus(hb));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] rr_exp_g [5];
  logic [1:0] rr_exp_id [5];

  initial begin
    rr_exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    fb.busreq = '0; fb.ready = 1'b1; fb.response = RESP_OKAY; fb.hsplit = '0;
    rb.busreq = '0; rb.ready = 1'b1; rb.response = RESP_OKAY; rb.hsplit = '0;
    hb.busreq = '0; hb.ready = 1'b1; hb.response = RESP_OKAY; hb.hsplit = '0;

    // Reset values
    #12;
    chk("rst_grant", 32'(fb.grant), 32'h0);
    chk("rst_id", 32'(fb.master_id), 32'h0);
    chk("rst_addr", 32'(fb.addr_phase), 32'h0);
    chk("rst_data", 32'(fb.data_phase), 32'h0);
    chk("rst_split", 32'(fb.split_mask), 32'h0);
    chk("rst_error", 32'(fb.error), 32'h0);
    chk("rst_rr_grant", 32'(rb.grant), 32'h0);
    #10 rst = 1'b1;

    // Fixed priority: master 0 wins and keeps the bus while requesting
    fb.busreq = 2'b11;
    tick(1);
    chk("fix_grant0", 32'(fb.grant), 32'h1);
    chk("fix_id0", 32'(fb.master_id), 32'h0);
    chk("fix_addr0", 32'(fb.addr_phase), 32'h1);
    tick(1);
    chk("fix_data0", 32'(fb.data_phase), 32'h1);
    tick(1);
    chk("fix_keep0", 32'(fb.grant), 32'h1);
    fb.busreq = 2'b10;
    tick(2);
    chk("fix_grant1", 32'(fb.grant), 32'h2);
    chk("fix_id1", 32'(fb.master_id), 32'h1);

    // SPLIT on master 1 with master 0 waiting
    fb.busreq = 2'b11;
    tick(1);
    fb.ready = 1'b0; fb.response = RESP_SPLIT;
    tick(1);
    chk("split_rel_grant", 32'(fb.grant), 32'h0);
    chk("split_rel_addr", 32'(fb.addr_phase), 32'h0);
    chk("split_rel_data", 32'(fb.data_phase), 32'h0);
    chk("split_mask_set", 32'(fb.split_mask), 32'h2);
    chk("split_rel_id", 32'(fb.master_id), 32'h1);
    fb.ready = 1'b1;
    tick(1);
    chk("split_to_m0", 32'(fb.grant), 32'h1);
    chk("split_mask_hold", 32'(fb.split_mask), 32'h2);
    fb.response = RESP_OKAY; fb.hsplit = 2'b10;
    tick(1);
    chk("unsplit_clear", 32'(fb.split_mask), 32'h0);
    fb.hsplit = 2'b00; fb.busreq = 2'b10;
    tick(1);
    chk("unsplit_regrant", 32'(fb.grant), 32'h2);

    // ERROR: one-cycle pulse then re-arbitration
    tick(1);
    fb.ready = 1'b0; fb.response = RESP_ERROR;
    tick(1);
    chk("err_pulse", 32'(fb.error), 32'h1);
    chk("err_rel_grant", 32'(fb.grant), 32'h0);
    fb.ready = 1'b1;
    tick(1);
    chk("err_pulse_end", 32'(fb.error), 32'h0);
    chk("err_regrant", 32'(fb.grant), 32'h2);

    // Wait states, then RETRY
    fb.response = RESP_OKAY; fb.ready = 1'b0;
    tick(1);
    chk("addr_wait", 32'(fb.addr_phase), 32'h1);
    fb.ready = 1'b1;
    tick(1);
    fb.ready = 1'b0;
    tick(1);
    chk("data_wait", 32'(fb.data_phase), 32'h1);
    chk("data_wait_grant", 32'(fb.grant), 32'h2);
    fb.response = RESP_RETRY;
    tick(1);
    chk("retry_grant", 32'(fb.grant), 32'h0);
    chk("retry_error", 32'(fb.error), 32'h0);
    chk("retry_mask", 32'(fb.split_mask), 32'h0);
    chk("retry_data", 32'(fb.data_phase), 32'h0);
    fb.ready = 1'b1; fb.response = RESP_OKAY; fb.busreq = 2'b00;
    tick(1);
    chk("idle_grant", 32'(fb.grant), 32'h0);
    chk("idle_id_hold", 32'(fb.master_id), 32'h1);
    chk("idle_addr", 32'(fb.addr_phase), 32'h0);

    // Round robin, MAX_HOLD=1: park the pointer on master 3 first
    rb.busreq = 4'b1000;
    tick(1);
    chk("rr_first", 32'(rb.grant), 32'h8);
    rb.busreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(2);
      chk("rr_cycle_grant", 32'(rb.grant), 32'(rr_exp_g[i]));
      chk("rr_cycle_id", 32'(rb.master_id), 32'(rr_exp_id[i]));
    end

    // Round robin, MAX_HOLD=4: master 0 yields after four transfers
    hb.busreq = 2'b01;
    tick(1);
    chk("hold_start", 32'(hb.grant), 32'h1);
    hb.busreq = 2'b11;
    tick(6);
    chk("hold_still_m0", 32'(hb.grant), 32'h1);
    chk("hold_addr", 32'(hb.addr_phase), 32'h1);
    tick(2);
    chk("hold_switch", 32'(hb.grant), 32'h2);
    chk("hold_switch_id", 32'(hb.master_id), 32'h1);

    // Async reset mid-DATA with a pending split
    fb.busreq = 2'b01;
    tick(2);
    fb.ready = 1'b0; fb.response = RESP_SPLIT;
    tick(1);
    fb.ready = 1'b1; fb.response = RESP_OKAY; fb.busreq = 2'b10;
    tick(2);
    fb.ready = 1'b0;
    chk("pre_rst_mask", 32'(fb.split_mask), 32'h1);
    chk("pre_rst_data", 32'(fb.data_phase), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_grant", 32'(fb.grant), 32'h0);
    chk("arst_data", 32'(fb.data_phase), 32'h0);
    chk("arst_mask", 32'(fb.split_mask), 32'h0);
    chk("arst_id", 32'(fb.master_id), 32'h0);
    fb.busreq = 2'b00; fb.ready = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("post_rst_nogrant", 32'(fb.grant), 32'h0);
    fb.busreq = 2'b01;
    tick(1);
    chk("post_rst_grant", 32'(fb.grant), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
